// File: rtl/scanner_ctrl.sv
// scanner_ctrl: acquisition controller for a two-scanner link.
// Fills a buffer level at a divide-by-8 rate while scanning, holds it in
// READY until the peer grants the link, then drains it serially over
// clkOut/dataOut.
// Optional feature macro: SCANNER_ABORT_EN (command 10 aborts SCAN/READY).
module scanner_ctrl #(
   parameter logic [3:0] FULL_LEVEL = 4'd10
) (
   output logic [2:0] slowCount,
   output logic [3:0] dataBuffer,
   output logic [1:0] ps,
   input  logic       clk,
   input  logic       rst,
   input  logic       readyForTransferIn,
   input  logic [1:0] localTransferInput,
   output logic       clkOut,
   output logic       dataOut
);

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      SCAN     = 2'b01,
      READY    = 2'b10,
      TRANSFER = 2'b11
   } state_t;

   localparam logic [3:0] FULL_M1 = FULL_LEVEL - 4'd1;

   state_t     state_q;
   logic [2:0] slow_q;
   logic [3:0] buf_q;
   logic       tick;
   logic       abort_req;

   assign tick = (slow_q == 3'd7);

`ifdef SCANNER_ABORT_EN
   assign abort_req = (localTransferInput == 2'b10);
`else
   assign abort_req = 1'b0;
`endif

   // Controller state, divider and buffer level, all updated together
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         slow_q  <= '0;
         buf_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               slow_q <= '0;
               if (localTransferInput == 2'b01) begin
                  state_q <= SCAN;
               end
            end
            SCAN: begin
               if (abort_req) begin
                  state_q <= IDLE;
                  slow_q  <= '0;
                  buf_q   <= '0;
               end else begin
                  slow_q <= slow_q + 3'd1;
                  if (tick) begin
                     // >= rather than == so the level can never climb past full
                     if (buf_q >= FULL_M1) begin
                        buf_q   <= FULL_LEVEL;
                        state_q <= READY;
                     end else begin
                        buf_q <= buf_q + 4'd1;
                     end
                  end
               end
            end
            READY: begin
               slow_q <= '0;
               if (abort_req) begin
                  state_q <= IDLE;
                  buf_q   <= '0;
               end else if (readyForTransferIn) begin
                  state_q <= TRANSFER;
               end
            end
            TRANSFER: begin
               slow_q <= slow_q + 3'd1;
               if (tick) begin
                  // an empty buffer also exits here, on the first tick
                  if (buf_q <= 4'd1) begin
                     buf_q   <= '0;
                     slow_q  <= '0;
                     state_q <= IDLE;
                  end else begin
                     buf_q <= buf_q - 4'd1;
                  end
               end
            end
         endcase
      end
   end

   assign ps         = state_q;
   assign slowCount  = slow_q;
   assign dataBuffer = buf_q;
   assign clkOut     = (state_q == TRANSFER) && slow_q[2];
   assign dataOut    = (state_q == TRANSFER) && (buf_q != '0);

endmodule

// File: tb/tb_scanner_ctrl.sv
// Bench for scanner_ctrl: directed scenarios with literal expectations,
// then randomized commands checked every cycle against a level/time model.
module tb_scanner_ctrl;

   localparam int FULL = 10;
`ifdef SCANNER_ABORT_EN
   localparam bit ABORT = 1'b1;
`else
   localparam bit ABORT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       rft;
   logic [1:0] lti;
   logic [2:0] slowCount;
   logic [3:0] dataBuffer;
   logic [1:0] ps;
   logic       clkOut;
   logic       dataOut;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;

   scanner_ctrl #(.FULL_LEVEL(4'd10)) dut (
      .slowCount          (slowCount),
      .dataBuffer         (dataBuffer),
      .ps                 (ps),
      .clk                (clk),
      .rst                (rst),
      .readyForTransferIn (rft),
      .localTransferInput (lti),
      .clkOut             (clkOut),
      .dataOut            (dataOut)
   );

   always #5 clk = ~clk;

   // Model: mode, cycles spent in the mode, and level when the mode began.
   int mode = 0;
   int cyc  = 0;
   int lvl0 = 0;

   function automatic int lvl_now();
      int v;
      case (mode)
         1: begin v = lvl0 + cyc / 8; if (v > FULL) v = FULL; end
         3: begin v = lvl0 - cyc / 8; if (v < 0) v = 0; end
         default: v = lvl0;
      endcase
      return v;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         mode = 0; cyc = 0; lvl0 = 0;
      end else begin
         case (mode)
            0: if (lti == 2'b01) begin mode = 1; cyc = 0; end
            1: begin
               if (ABORT && lti == 2'b10) begin
                  mode = 0; cyc = 0; lvl0 = 0;
               end else begin
                  cyc++;
                  if (lvl_now() >= FULL) begin mode = 2; lvl0 = FULL; cyc = 0; end
               end
            end
            2: begin
               if (ABORT && lti == 2'b10) begin
                  mode = 0; cyc = 0; lvl0 = 0;
               end else if (rft) begin
                  mode = 3; cyc = 0;
               end
            end
            default: begin
               cyc++;
               if (cyc % 8 == 0 && lvl_now() == 0) begin mode = 0; cyc = 0; lvl0 = 0; end
            end
         endcase
      end
   end

   // Every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      int e_slow, e_lvl, e_ck, e_do;
      if (chk_en) begin
         e_lvl  = lvl_now();
         e_slow = (mode == 1 || mode == 3) ? (cyc % 8) : 0;
         e_ck   = (mode == 3 && e_slow >= 4) ? 1 : 0;
         e_do   = (mode == 3 && e_lvl != 0) ? 1 : 0;
         vectors++;
         if (int'(ps) != mode || int'(slowCount) != e_slow || int'(dataBuffer) != e_lvl ||
             int'(clkOut) != e_ck || int'(dataOut) != e_do) begin
            miscompares++;
            $display("FAIL model t=%0t: got ps=%0d slow=%0d buf=%0d ck=%0d do=%0d, expected ps=%0d slow=%0d buf=%0d ck=%0d do=%0d",
                     $time, ps, slowCount, dataBuffer, clkOut, dataOut,
                     mode, e_slow, e_lvl, e_ck, e_do);
         end
      end
   end

   task automatic nxt(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic lit(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   initial begin
      rst = 1'b1; lti = 2'b00; rft = 1'b0;
      nxt(1);
      chk_en = 1'b1;
      // reset state
      lit("rst_ps", int'(ps), 0);
      lit("rst_buf", int'(dataBuffer), 0);
      lit("rst_slow", int'(slowCount), 0);
      lit("rst_ck", int'(clkOut), 0);
      lit("rst_do", int'(dataOut), 0);

      // scan to full
      rst = 1'b0; lti = 2'b01;
      nxt(1);
      lit("scan_entry", int'(ps), 1);
      lti = 2'b00;
      nxt(8);
      lit("scan_8", int'(dataBuffer), 1);
      nxt(42);
      lit("scan_50", int'(dataBuffer), 6);
      nxt(29);
      lit("scan_79_ps", int'(ps), 1);
      nxt(1);
      lit("scan_80_ps", int'(ps), 2);
      lit("scan_80_buf", int'(dataBuffer), 10);

      // hold in READY
      nxt(20);
      lit("ready_ps", int'(ps), 2);
      lit("ready_buf", int'(dataBuffer), 10);
      lit("ready_slow", int'(slowCount), 0);

      // transfer
      rft = 1'b1;
      nxt(1);
      rft = 1'b0;
      lit("xfer_entry", int'(ps), 3);
      for (int k = 0; k < 8; k++) begin
         lit("xfer_clkout", int'(clkOut), (k >= 4) ? 1 : 0);
         lit("xfer_dout", int'(dataOut), 1);
         nxt(1);
      end
      lit("xfer_8_buf", int'(dataBuffer), 9);
      nxt(8);
      lit("xfer_16_buf", int'(dataBuffer), 8);
      nxt(63);
      lit("xfer_79_buf", int'(dataBuffer), 1);
      nxt(1);
      lit("xfer_80_ps", int'(ps), 0);
      lit("xfer_80_buf", int'(dataBuffer), 0);
      lit("xfer_80_do", int'(dataOut), 0);

      // reset mid-scan
      lti = 2'b01;
      nxt(1);
      lti = 2'b00;
      nxt(24);
      lit("midscan_buf", int'(dataBuffer), 3);
      rst = 1'b1;
      nxt(1);
      lit("midrst_ps", int'(ps), 0);
      lit("midrst_buf", int'(dataBuffer), 0);
      lit("midrst_slow", int'(slowCount), 0);
      rst = 1'b0;

      // abort command during scan
      lti = 2'b01;
      nxt(1);
      lti = 2'b00;
      nxt(10);
      lti = 2'b10;
      nxt(1);
      lti = 2'b00;
      lit("abort_ps", int'(ps), ABORT ? 0 : 1);
      lit("abort_buf", int'(dataBuffer), ABORT ? 0 : 1);
      lit("abort_slow", int'(slowCount), ABORT ? 0 : 3);

      // randomized commands, grants and occasional resets
      for (int i = 0; i < 6000; i++) begin
         int r;
         rst = ($urandom_range(0, 699) == 0);
         r = $urandom_range(0, 63);
         if (r < 1)      lti = 2'b10;
         else if (r < 5) lti = 2'b01;
         else            lti = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
         rft = ($urandom_range(0, 3) == 0);
         nxt(1);
      end

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
